// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/execute stage: opcodes, stage FSM states,
// and the legal-opcode check.
package alu_pkg;

  localparam logic [3:0] OpAnd      = 4'b0000;
  localparam logic [3:0] OpOr       = 4'b0001;
  localparam logic [3:0] OpAdd      = 4'b0010;
  localparam logic [3:0] OpSub      = 4'b0110;
  localparam logic [3:0] OpLessThan = 4'b0111;
  localparam logic [3:0] OpNor      = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  function automatic logic is_legal(input logic [3:0] ctl);
    case (ctl)
      OpAnd, OpOr, OpAdd, OpSub, OpLessThan, OpNor: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, modular add/sub with signed overflow, signed less-than.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 11
) (
  input  logic [3:0]   ALUctl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] ALUout,
  output logic         Overflow,
  output logic         Zero
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         lt;

  assign sum  = A + B;
  assign diff = A - B;
  assign lt   = $signed(A) < $signed(B);

  always_comb begin
    ALUout   = '0;
    Overflow = 1'b0;
    case (ALUctl)
      OpAnd: ALUout = A & B;
      OpOr:  ALUout = A | B;
      OpAdd: begin
        ALUout   = sum;
        Overflow = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OpSub: begin
        ALUout   = diff;
        Overflow = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OpLessThan: ALUout = {{(W-1){1'b0}}, lt};
      OpNor:      ALUout = ~(A | B);
      default:    ALUout = '0;
    endcase
  end

  assign Zero = (ALUout == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered issue/execute stage around the ALU: valid/ready in, one EXEC cycle, registered
// result out, plus a sticky overflow flag and a wrap-around capture counter.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned W  = 11,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_ctl,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic          out_ovf,
  output logic          out_zero,
  output logic          out_err,
  input  logic          clr_sticky,
  output logic          sticky_ovf,
  output logic [CW-1:0] op_count
);

  state_e        state_q, state_d;
  logic [3:0]    ctl_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  result_q;
  logic          ovf_q, zero_q, err_q, sticky_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  alu_out;
  logic          alu_ovf, alu_zero;
  logic          accept, capture, legal;

  alu #(.W(W)) u_alu (
    .ALUctl   (ctl_q),
    .A        (a_q),
    .B        (b_q),
    .ALUout   (alu_out),
    .Overflow (alu_ovf),
    .Zero     (alu_zero)
  );

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;
  assign capture  = (state_q == StExec);
  assign legal    = is_legal(ctl_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (out_ready) state_d = in_valid ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ctl_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctl_q <= in_ctl;
        a_q   <= in_a;
        b_q   <= in_b;
      end
      if (capture) begin
        // Illegal codes mask the ALU outputs entirely.
        result_q <= legal ? alu_out : '0;
        ovf_q    <= legal && alu_ovf;
        zero_q   <= legal && alu_zero;
        err_q    <= !legal;
        count_q  <= count_q + CW'(1);
      end
      if (capture && legal && alu_ovf) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;
  assign sticky_ovf = sticky_q;
  assign op_count   = count_q;

endmodule
